// File: rtl/exp4_unidade_controle_jogadas_pkg.sv
// +--------------------------------------------------------------------+
// | exp4_unidade_controle_jogadas_pkg: state codes and defaults         |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

package exp4_unidade_controle_jogadas_pkg;

  localparam int TIMEOUT_DEFAULT = 5000;

  localparam logic [3:0] EST_INICIAL     = 4'h0;
  localparam logic [3:0] EST_PREPARACAO  = 4'h1;
  localparam logic [3:0] EST_ESPERA      = 4'h2;
  localparam logic [3:0] EST_REGISTRA    = 4'h4;
  localparam logic [3:0] EST_COMPARACAO  = 4'h5;
  localparam logic [3:0] EST_PROXIMO     = 4'h6;
  localparam logic [3:0] EST_FIM_ACERTO  = 4'hA;
  localparam logic [3:0] EST_FIM_TIMEOUT = 4'hD;
  localparam logic [3:0] EST_FIM_ERRO    = 4'hE;

  typedef enum logic [3:0] {
    S_INICIAL     = EST_INICIAL,
    S_PREPARACAO  = EST_PREPARACAO,
    S_ESPERA      = EST_ESPERA,
    S_REGISTRA    = EST_REGISTRA,
    S_COMPARACAO  = EST_COMPARACAO,
    S_PROXIMO     = EST_PROXIMO,
    S_FIM_ACERTO  = EST_FIM_ACERTO,
    S_FIM_TIMEOUT = EST_FIM_TIMEOUT,
    S_FIM_ERRO    = EST_FIM_ERRO
  } estado_t;

endpackage

`default_nettype wire

// File: rtl/exp4_unidade_controle_jogadas_contador_timeout.sv
// +--------------------------------------------------------------------+
// | contador_timeout: move-wait counter, fim at terminal count           |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module contador_timeout #(
  parameter int TIMEOUT = 5000,
  parameter int TMO_W   = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic zera,
  input  logic conta,
  output logic fim
);

  logic [TMO_W-1:0] count_q;
  logic [TMO_W-1:0] count_d;

  // Clear has priority so a move on the last cycle restarts from zero.
  always_comb begin
    count_d = count_q;
    if (zera) begin
      count_d = '0;
    end else if (conta) begin
      count_d = count_q + TMO_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign fim = (count_q == TMO_W'(TIMEOUT - 1));

endmodule

`default_nettype wire

// File: rtl/exp4_unidade_controle_jogadas.sv
// +--------------------------------------------------------------------+
// | exp4_unidade_controle_jogadas: play-round control FSM               |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module exp4_unidade_controle_jogadas
  import exp4_unidade_controle_jogadas_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT,
  parameter int TMO_W   = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       jogada,
  input  logic       fimC,
  input  logic       chavesIgualMemoria,
  output logic       zeraC,
  output logic       contaC,
  output logic       zeraR,
  output logic       registraR,
  output logic       pronto,
  output logic       acertou,
  output logic       errou,
  output logic       timeout,
  output logic [3:0] db_estado
);

  estado_t state_q;
  estado_t state_d;
  logic    acertou_q, acertou_d;
  logic    errou_q, errou_d;
  logic    timeout_q, timeout_d;

  logic    tmo_zera;
  logic    tmo_conta;
  logic    tmo_fim;

  assign tmo_zera  = (state_q == S_PREPARACAO) || (state_q == S_PROXIMO) ||
                     ((state_q == S_ESPERA) && jogada);
  assign tmo_conta = (state_q == S_ESPERA);

  contador_timeout #(
    .TIMEOUT (TIMEOUT),
    .TMO_W   (TMO_W)
  ) u_contador_timeout (
    .clock (clock),
    .reset (reset),
    .zera  (tmo_zera),
    .conta (tmo_conta),
    .fim   (tmo_fim)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_INICIAL:     if (iniciar) state_d = S_PREPARACAO;
      S_PREPARACAO:  state_d = S_ESPERA;
      S_ESPERA: begin
        if (jogada) begin
          state_d = S_REGISTRA;
        end else if (tmo_fim) begin
          state_d = S_FIM_TIMEOUT;
        end
      end
      S_REGISTRA:    state_d = S_COMPARACAO;
      S_COMPARACAO: begin
        if (!chavesIgualMemoria) begin
          state_d = S_FIM_ERRO;
        end else if (fimC) begin
          state_d = S_FIM_ACERTO;
        end else begin
          state_d = S_PROXIMO;
        end
      end
      S_PROXIMO:     state_d = S_ESPERA;
      S_FIM_ACERTO,
      S_FIM_TIMEOUT,
      S_FIM_ERRO:    if (iniciar) state_d = S_PREPARACAO;
      default:       state_d = S_INICIAL;
    endcase
  end

  // FIM states are only left through PREPARACAO, so tracking the next
  // state both sets the flag on entry and clears it on restart.
  always_comb begin
    acertou_d = (state_d == S_FIM_ACERTO);
    errou_d   = (state_d == S_FIM_ERRO);
    timeout_d = (state_d == S_FIM_TIMEOUT);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_INICIAL;
      acertou_q <= 1'b0;
      errou_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acertou_q <= acertou_d;
      errou_q   <= errou_d;
      timeout_q <= timeout_d;
    end
  end

  assign zeraC     = (state_q == S_PREPARACAO);
  assign zeraR     = (state_q == S_PREPARACAO);
  assign contaC    = (state_q == S_PROXIMO);
  assign registraR = (state_q == S_REGISTRA);
  assign pronto    = (state_q == S_FIM_ACERTO) || (state_q == S_FIM_TIMEOUT) ||
                     (state_q == S_FIM_ERRO);
  assign acertou   = acertou_q;
  assign errou     = errou_q;
  assign timeout   = timeout_q;
  assign db_estado = state_q;

endmodule

`default_nettype wire
